// File: rtl/rdm_threshold_detect_if.sv
// AXI-Stream amplitude channel into rdm_threshold_detect (second pass over the RDM).
interface rdm_threshold_detect_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;

  modport master (output s_axis_tvalid, s_axis_tdata, s_axis_tlast, input s_axis_tready);
  modport slave  (input s_axis_tvalid, s_axis_tdata, s_axis_tlast, output s_axis_tready);
endinterface

// File: rtl/rdm_threshold_detect.sv
// Per-row CFAR threshold compare over the RDM amplitude stream, with detection count and error flags.
// Optional macro RDM_DET_LOCAL_PEAK_EN adds a local-peak (left/right neighbour) qualifier.
module rdm_threshold_detect #(
  parameter int ROW_LEN       = 32,
  parameter int NUM_ROWS      = 2048,
  parameter int ROW_W         = 12,
  parameter int COL_W         = 8,
  parameter int TH_FIFO_DEPTH = 16
) (
  input  logic                 clk_100mhz,
  input  logic                 reset_n,
  input  logic                 th_vld,
  input  logic [15:0]          th_data,
  rdm_threshold_detect_if.slave axis,
  output logic                 det_vld,
  output logic [31:0]          det_amp,
  output logic [ROW_W-1:0]     det_row,
  output logic [COL_W-1:0]     det_col,
  output logic                 frame_done,
  output logic [15:0]          det_count,
  output logic                 th_ovf,
  output logic                 frame_err,
  input  logic                 clr_err
);
  localparam int AW = $clog2(TH_FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_TH, LOAD, RUN, FLUSH, DONE} state_t;
  state_t state;

  logic [15:0]      fifo_mem [TH_FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, push, pop, flush;
  logic             tready, accept, row_end, final_cell;
  logic             frame_end, frame_early;
  logic [15:0]      thr, hit_cnt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
`ifdef RDM_DET_LOCAL_PEAK_EN
  logic [31:0]      left_amp_p1, cand_amp_p1;
  logic [COL_W-1:0] cand_col_p1;
`endif

  function automatic logic above(input logic [31:0] amp, input logic [15:0] th);
    return amp > {16'b0, th};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

`ifdef RDM_DET_LOCAL_PEAK_EN
  function automatic logic is_peak(input logic [31:0] amp, input logic [31:0] left,
                                   input logic [31:0] right, input logic [15:0] th);
    return above(amp, th) && (amp >= left) && (amp > right);
  endfunction
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = th_vld && !fifo_full;
  assign pop        = (state == LOAD);
  assign flush      = (state == DONE) && frame_early;

  assign axis.s_axis_tready = tready;
  assign accept     = axis.s_axis_tvalid && tready;
  assign row_end    = (col == COL_W'(ROW_LEN - 1));
  assign final_cell = row_end && (row == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk_100mhz) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= th_data;
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      // Dropping everything queued after an early tlast keeps the next frame aligned to row 0.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_TH;
      tready      <= 1'b0;
      thr         <= '0;
      row         <= '0;
      col         <= '0;
      frame_end   <= 1'b0;
      frame_early <= 1'b0;
      hit_cnt     <= '0;
      det_vld     <= 1'b0;
      det_amp     <= '0;
      det_row     <= '0;
      det_col     <= '0;
      frame_done  <= 1'b0;
      det_count   <= '0;
      th_ovf      <= 1'b0;
      frame_err   <= 1'b0;
`ifdef RDM_DET_LOCAL_PEAK_EN
      left_amp_p1 <= '0;
      cand_amp_p1 <= '0;
      cand_col_p1 <= '0;
`endif
    end else begin
      det_vld    <= 1'b0;
      frame_done <= 1'b0;

      if (th_vld && fifo_full) th_ovf <= 1'b1;
      else if (clr_err)        th_ovf <= 1'b0;

      // tlast must coincide exactly with the final cell of the frame.
      if (accept && (axis.s_axis_tlast != final_cell)) frame_err <= 1'b1;
      else if (clr_err)                                frame_err <= 1'b0;

`ifdef RDM_DET_LOCAL_PEAK_EN
      // Stage p1: hold one candidate until its right neighbour (or row end) is known.
      if (accept) begin
        if (col != '0 && is_peak(cand_amp_p1, left_amp_p1, axis.s_axis_tdata, thr)) begin
          det_vld <= 1'b1;
          det_amp <= cand_amp_p1;
          det_row <= row;
          det_col <= cand_col_p1;
          hit_cnt <= sat_inc(hit_cnt);
        end
        left_amp_p1 <= (col == '0) ? '0 : cand_amp_p1;
        cand_amp_p1 <= axis.s_axis_tdata;
        cand_col_p1 <= col;
      end
      if (state == FLUSH && is_peak(cand_amp_p1, left_amp_p1, 32'd0, thr)) begin
        det_vld <= 1'b1;
        det_amp <= cand_amp_p1;
        det_row <= row;
        det_col <= cand_col_p1;
        hit_cnt <= sat_inc(hit_cnt);
      end
`else
      if (accept && above(axis.s_axis_tdata, thr)) begin
        det_vld <= 1'b1;
        det_amp <= axis.s_axis_tdata;
        det_row <= row;
        det_col <= col;
        hit_cnt <= sat_inc(hit_cnt);
      end
`endif

      case (state)
        WAIT_TH: if (!fifo_empty) state <= LOAD;
        LOAD: begin
          thr    <= fifo_mem[rd_ptr[AW-1:0]];
          tready <= 1'b1;
          state  <= RUN;
        end
        RUN: if (accept) begin
          col <= col + COL_W'(1);
          if (axis.s_axis_tlast) frame_end <= 1'b1;
          if (axis.s_axis_tlast && !final_cell) frame_early <= 1'b1;
          if (row_end || axis.s_axis_tlast) begin
            tready <= 1'b0;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          col <= '0;
          if (frame_end || row == ROW_W'(NUM_ROWS - 1)) begin
            state <= DONE;
          end else begin
            row   <= row + ROW_W'(1);
            state <= WAIT_TH;
          end
        end
        DONE: begin
          frame_done  <= 1'b1;
          det_count   <= hit_cnt;
          hit_cnt     <= '0;
          row         <= '0;
          frame_end   <= 1'b0;
          frame_early <= 1'b0;
          state       <= WAIT_TH;
        end
        default: state <= WAIT_TH;
      endcase
    end
  end
endmodule

// File: tb/tb_rdm_threshold_detect.sv
// Self-checking bench for rdm_threshold_detect: table vectors, corner sequences and random frames vs a scoreboard model.
module tb_rdm_threshold_detect;
  localparam int ROW_LEN       = 4;
  localparam int NUM_ROWS      = 2;
  localparam int ROW_W         = 4;
  localparam int COL_W         = 4;
  localparam int TH_FIFO_DEPTH = 4;

  logic             clk_100mhz, reset_n, th_vld, clr_err;
  logic [15:0]      th_data;
  logic             det_vld, frame_done, th_ovf, frame_err;
  logic [31:0]      det_amp;
  logic [ROW_W-1:0] det_row;
  logic [COL_W-1:0] det_col;
  logic [15:0]      det_count;

  rdm_threshold_detect_if axis();

  rdm_threshold_detect #(
    .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .COL_W(COL_W),
    .TH_FIFO_DEPTH(TH_FIFO_DEPTH)
  ) dut (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .th_vld(th_vld), .th_data(th_data),
    .axis(axis), .det_vld(det_vld), .det_amp(det_amp), .det_row(det_row), .det_col(det_col),
    .frame_done(frame_done), .det_count(det_count), .th_ovf(th_ovf), .frame_err(frame_err),
    .clr_err(clr_err)
  );

  typedef struct { logic [31:0] amp; int row; int col; } det_t;
  typedef struct { logic [31:0] data; bit last; bit hit; int row; int col; } vec_t;

  det_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_pulses = 0;

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_100mhz) begin
    if (frame_done) done_pulses++;
    if (det_vld) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL det_unexpected: got amp 0x%0h row %0d col %0d, want no detection",
                 det_amp, det_row, det_col);
      end else begin
        det_t e;
        e = sb.pop_front();
        check("det_amp", det_amp, e.amp);
        check("det_row", 32'(det_row), 32'(e.row));
        check("det_col", 32'(det_col), 32'(e.col));
      end
    end
  end

  // Reference: a cell is a detection when it strictly exceeds its row threshold
  // (and, with the peak option, is >= its left and > its right neighbour in the received row).
  function automatic bit model_hit(input logic [31:0] rowc[$], input int c, input logic [15:0] th);
    bit h;
    h = rowc[c] > {16'h0, th};
`ifdef RDM_DET_LOCAL_PEAK_EN
    begin
      logic [31:0] l, r;
      l = (c == 0) ? 32'd0 : rowc[c-1];
      r = (c == rowc.size() - 1) ? 32'd0 : rowc[c+1];
      h = h && (rowc[c] >= l) && (rowc[c] > r);
    end
`endif
    return h;
  endfunction

  task automatic expect_frame(input logic [31:0] cells[$], input logic [15:0] ths[$],
                              output int cnt, output bit err);
    logic [31:0] rowc[$];
    det_t d;
    cnt = 0;
    for (int r = 0; r * ROW_LEN < cells.size(); r++) begin
      rowc.delete();
      for (int c = 0; c < ROW_LEN && r * ROW_LEN + c < cells.size(); c++)
        rowc.push_back(cells[r * ROW_LEN + c]);
      for (int c = 0; c < rowc.size(); c++) begin
        if (model_hit(rowc, c, ths[r])) begin
          d.amp = rowc[c]; d.row = r; d.col = c;
          sb.push_back(d);
          cnt++;
        end
      end
    end
    err = (cells.size() != NUM_ROWS * ROW_LEN);
  endtask

  task automatic push_th(input logic [15:0] v);
    th_vld = 1'b1; th_data = v;
    @(posedge clk_100mhz); #1;
    th_vld = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input bit l);
    bit done;
    int n;
    done = 0; n = 0;
    axis.s_axis_tvalid = 1'b1; axis.s_axis_tdata = d; axis.s_axis_tlast = l;
    while (!done && n < 100) begin
      @(negedge clk_100mhz);
      if (axis.s_axis_tready) begin
        @(posedge clk_100mhz); #1;
        done = 1;
      end
      n++;
    end
    axis.s_axis_tvalid = 1'b0; axis.s_axis_tlast = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout: tready never seen for 0x%0h, want accept within 100 cycles", d);
    end
  endtask

  task automatic send_cells(input logic [31:0] cells[$], input int from, input bit gaps);
    for (int i = from; i < cells.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk_100mhz);
        #1;
      end
      drive_beat(cells[i], i == cells.size() - 1);
    end
  endtask

  task automatic finish_frame(input int exp_cnt, input bit exp_err);
    int start, n;
    start = done_pulses; n = 0;
    while (done_pulses == start && n < 50) begin
      @(posedge clk_100mhz); n++;
    end
    repeat (4) @(posedge clk_100mhz);
    #1;
    check("frame_done_pulses", 32'(done_pulses - start), 1);
    check("det_count", 32'(det_count), 32'(exp_cnt));
    check("frame_err", 32'(frame_err), 32'(exp_err));
    check("sb_drained", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] cells[$];
    logic [15:0] ths[$];
    int          cnt, hi;
    bit          err;

    tbl[0] = '{32'h0200, 0, 0, 0, 0};
    tbl[1] = '{32'h0301, 0, 1, 0, 1};
    tbl[2] = '{32'h0300, 0, 0, 0, 2};
    tbl[3] = '{32'h1000, 0, 1, 0, 3};
    tbl[4] = '{32'h0501, 0, 1, 1, 0};
    tbl[5] = '{32'h0000, 0, 0, 1, 1};
    tbl[6] = '{32'h0000, 0, 0, 1, 2};
    tbl[7] = '{32'h0000, 1, 0, 1, 3};

    reset_n = 1'b0; th_vld = 1'b0; th_data = '0; clr_err = 1'b0;
    axis.s_axis_tvalid = 1'b0; axis.s_axis_tdata = '0; axis.s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1 reset_n = 1'b1;
    @(negedge clk_100mhz);
    check("rst_det_vld", 32'(det_vld), 0);
    check("rst_tready", 32'(axis.s_axis_tready), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_det_count", 32'(det_count), 0);
    check("rst_th_ovf", 32'(th_ovf), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    @(posedge clk_100mhz); #1;

    // Basic two-row frame from the table, including the amp == threshold boundary.
    ths = '{16'h0300, 16'h0500};
    cells.delete();
    for (int i = 0; i < 8; i++) cells.push_back(tbl[i].data);
    expect_frame(cells, ths, cnt, err);
    push_th(ths[0]); push_th(ths[1]);
    for (int i = 0; i < 8; i++) begin
      drive_beat(tbl[i].data, tbl[i].last);
`ifndef RDM_DET_LOCAL_PEAK_EN
      check("tbl_det_vld", 32'(det_vld), 32'(tbl[i].hit));
      if (tbl[i].hit) begin
        check("tbl_det_row", 32'(det_row), 32'(tbl[i].row));
        check("tbl_det_col", 32'(det_col), 32'(tbl[i].col));
      end
`endif
    end
    finish_frame(3, 0);

    // No threshold queued: stream must stall, then open three cycles after th_vld.
    ths = '{16'h0100, 16'h0180};
    cells = '{32'h900, 32'h050, 32'h050, 32'h050, 32'h100, 32'h181, 32'h000, 32'h200};
    expect_frame(cells, ths, cnt, err);
    axis.s_axis_tvalid = 1'b1; axis.s_axis_tdata = cells[0]; axis.s_axis_tlast = 1'b0;
    hi = 0;
    repeat (20) begin
      @(negedge clk_100mhz);
      if (axis.s_axis_tready) hi++;
    end
    check("stall_tready_cycles", 32'(hi), 0);
    @(posedge clk_100mhz); #1;
    th_vld = 1'b1; th_data = ths[0];
    @(posedge clk_100mhz); #1;
    th_data = ths[1];
    @(posedge clk_100mhz); #1;
    th_vld = 1'b0;
    @(negedge clk_100mhz);
    check("tready_T2", 32'(axis.s_axis_tready), 0);
    @(posedge clk_100mhz); #1;
    @(negedge clk_100mhz);
    check("tready_T3", 32'(axis.s_axis_tready), 1);
    @(posedge clk_100mhz); #1;
    axis.s_axis_tvalid = 1'b0;
`ifndef RDM_DET_LOCAL_PEAK_EN
    check("first_det_latency", 32'(det_vld), 1);
`endif
    send_cells(cells, 1, 0);
    finish_frame(cnt, 0);

    // Threshold queue overflow: 1 latched + 4 queued, sixth value dropped.
    for (int i = 0; i < 6; i++) push_th(16'((i + 1) * 16'h100));
    check("th_ovf_set", 32'(th_ovf), 1);
    clr_err = 1'b1;
    @(posedge clk_100mhz); #1;
    clr_err = 1'b0;
    check("th_ovf_clr", 32'(th_ovf), 0);
    cells = '{32'h1A0, 32'h0, 32'h4A0, 32'h0, 32'h1A0, 32'h0, 32'h4A0, 32'h0};
    ths = '{16'h0100, 16'h0200};
    expect_frame(cells, ths, cnt, err);
    send_cells(cells, 0, 0);
    finish_frame(cnt, 0);
    ths = '{16'h0300, 16'h0400};
    expect_frame(cells, ths, cnt, err);
    send_cells(cells, 0, 0);
    finish_frame(cnt, 0);
    push_th(16'h0050);
    ths = '{16'h0500, 16'h0050};
    expect_frame(cells, ths, cnt, err);
    send_cells(cells, 0, 0);
    finish_frame(cnt, 0);

    // Early tlast at (0,2): error, frame closes, queued threshold discarded.
    push_th(16'h0100); push_th(16'h0100);
    cells = '{32'h200, 32'h050, 32'h300};
    ths = '{16'h0100};
    expect_frame(cells, ths, cnt, err);
    send_cells(cells, 0, 0);
    finish_frame(cnt, 1);
    hi = 0;
    repeat (10) begin
      @(negedge clk_100mhz);
      if (axis.s_axis_tready) hi++;
    end
    check("fifo_flushed_tready", 32'(hi), 0);
    @(posedge clk_100mhz); #1;
    clr_err = 1'b1;
    @(posedge clk_100mhz); #1;
    clr_err = 1'b0;
    check("frame_err_clr", 32'(frame_err), 0);
    ths = '{16'h0080, 16'h0900};
    cells = '{32'h081, 32'h000, 32'h080, 32'h0FF, 32'h901, 32'h000, 32'h900, 32'hA00};
    expect_frame(cells, ths, cnt, err);
    push_th(ths[0]); push_th(ths[1]);
    send_cells(cells, 0, 0);
    finish_frame(cnt, 0);

    // Random frames, each run back-to-back and then with random tvalid gaps.
    for (int k = 0; k < 4; k++) begin
      ths = '{16'($urandom_range(16'h200, 16'hC00)), 16'($urandom_range(16'h200, 16'hC00))};
      cells.delete();
      for (int i = 0; i < NUM_ROWS * ROW_LEN; i++) cells.push_back(32'($urandom_range(0, 32'h1000)));
      for (int g = 0; g < 2; g++) begin
        expect_frame(cells, ths, cnt, err);
        push_th(ths[0]); push_th(ths[1]);
        send_cells(cells, 0, g == 1);
        finish_frame(cnt, 0);
      end
    end

`ifdef RDM_DET_LOCAL_PEAK_EN
    // Plateau picks its right edge; last-cell peak appears one cycle after FLUSH.
    ths = '{16'h0100, 16'h0100};
    cells = '{32'h400, 32'h600, 32'h600, 32'h500, 32'h0, 32'h0, 32'h0, 32'h700};
    expect_frame(cells, ths, cnt, err);
    push_th(ths[0]); push_th(ths[1]);
    for (int i = 0; i < 3; i++) drive_beat(cells[i], 0);
    check("peak_plateau_left", 32'(det_vld), 0);
    drive_beat(cells[3], 0);
    check("peak_plateau_vld", 32'(det_vld), 1);
    check("peak_plateau_col", 32'(det_col), 2);
    for (int i = 4; i < 7; i++) drive_beat(cells[i], 0);
    drive_beat(cells[7], 1);
    check("peak_last_not_yet", 32'(det_vld), 0);
    @(posedge clk_100mhz); #1;
    check("peak_last_vld", 32'(det_vld), 1);
    check("peak_last_col", 32'(det_col), 3);
    finish_frame(2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
